// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between two requesters. One
//   transaction is in flight at a time and takes three cycles: accept,
//   memory access, response.
//
//   Arbitration is round-robin by default. Defining DMEM_ARB_FIXED_PRIO_EN
//   makes port 0 always win a contended arbitration.
//
// Parameters
//   n  data/address width of the requesters and the memory port
//   r  implemented memory address bits (2^r words)
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   reqValid*/reqWrite*          per-port request valid and store flag
//   reqAddr*/reqWriteData*       per-port word address and store data
//   reqReady*                    request accepted this cycle
//   respValid*                   one-cycle response strobe
//   respReadData*/respError*     load data / out-of-range flag with respValid
//   memWriteEnable/memAddr/
//   memWriteData/memReadData     memory port (combinational read, sync write)
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting for a request; reqReady may be granted
// ACCESS | memory is driven with the latched request
// RESP   | respValid pulses on the granted port
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reqValid0,
  input  logic         reqValid1,
  input  logic         reqWrite0,
  input  logic         reqWrite1,
  input  logic [n-1:0] reqAddr0,
  input  logic [n-1:0] reqAddr1,
  input  logic [n-1:0] reqWriteData0,
  input  logic [n-1:0] reqWriteData1,
  output logic         reqReady0,
  output logic         reqReady1,
  output logic         respValid0,
  output logic         respValid1,
  output logic [n-1:0] respReadData0,
  output logic [n-1:0] respReadData1,
  output logic         respError0,
  output logic         respError1,
  output logic         memWriteEnable,
  output logic [n-1:0] memAddr,
  output logic [n-1:0] memWriteData,
  input  logic [n-1:0] memReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t       state, state_nxt;
  logic         grant;       // 0: port 0 owns the transaction, 1: port 1
  logic         op_write;
  logic [n-1:0] lat_addr;
  logic [n-1:0] lat_data;
  logic [n-1:0] resp_data;
  logic         resp_err;
  logic         win0, win1;
  logic         accept;
  logic         in_range;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic         last_grant;  // port granted by the most recent transfer
`endif

  // Only the unimplemented upper address bits decide the range; in-range
  // addresses are used as-is and out-of-range ones are never folded back.
  assign in_range = ((lat_addr >> r) == '0);

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (reqValid0 && reqValid1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win0 = 1'b1;
`else
      win0 = last_grant;
      win1 = ~last_grant;
`endif
    end else begin
      win0 = reqValid0;
      win1 = reqValid1;
    end
  end

  always_comb begin
    state_nxt      = state;
    reqReady0      = 1'b0;
    reqReady1      = 1'b0;
    respValid0     = 1'b0;
    respValid1     = 1'b0;
    respReadData0  = '0;
    respReadData1  = '0;
    respError0     = 1'b0;
    respError1     = 1'b0;
    memWriteEnable = 1'b0;
    memAddr        = lat_addr;
    memWriteData   = lat_data;
    accept         = 1'b0;

    unique case (state)
      IDLE: begin
        // ready is suppressed while reset is held so it reads as 0 then
        reqReady0 = win0 & ~reset;
        reqReady1 = win1 & ~reset;
        accept    = reqReady0 | reqReady1;
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        memWriteEnable = op_write & in_range;
        state_nxt      = RESP;
      end
      RESP: begin
        if (grant) begin
          respValid1    = 1'b1;
          respReadData1 = resp_data;
          respError1    = resp_err;
        end else begin
          respValid0    = 1'b1;
          respReadData0 = resp_data;
          respError0    = resp_err;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      op_write  <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant    <= reqReady1;
        op_write <= reqReady1 ? reqWrite1     : reqWrite0;
        lat_addr <= reqReady1 ? reqAddr1      : reqAddr0;
        lat_data <= reqReady1 ? reqWriteData1 : reqWriteData0;
      end
      if (state == ACCESS) begin
        resp_data <= (in_range && !op_write) ? memReadData : '0;
        resp_err  <= ~in_range;
      end
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Reset to port 1 so port 0 wins the first contended arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= reqReady1;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int N = 32;
  localparam int R = 6;
  localparam int WORDS = 1 << R;

  logic         clk = 1'b0;
  logic         reset;
  logic         reqValid0, reqValid1, reqWrite0, reqWrite1;
  logic [N-1:0] reqAddr0, reqAddr1, reqWriteData0, reqWriteData1;
  logic         reqReady0, reqReady1, respValid0, respValid1;
  logic [N-1:0] respReadData0, respReadData1;
  logic         respError0, respError1;
  logic         memWriteEnable;
  logic [N-1:0] memAddr, memWriteData, memReadData;

  logic [N-1:0] mem [WORDS];

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.n(N), .r(R)) dut (
    .clk(clk), .reset(reset),
    .reqValid0(reqValid0), .reqValid1(reqValid1),
    .reqWrite0(reqWrite0), .reqWrite1(reqWrite1),
    .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
    .reqWriteData0(reqWriteData0), .reqWriteData1(reqWriteData1),
    .reqReady0(reqReady0), .reqReady1(reqReady1),
    .respValid0(respValid0), .respValid1(respValid1),
    .respReadData0(respReadData0), .respReadData1(respReadData1),
    .respError0(respError0), .respError1(respError1),
    .memWriteEnable(memWriteEnable), .memAddr(memAddr),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // Memory attached to the arbiter: combinational read, write on rising edge.
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 | i;
    forever begin
      @(posedge clk);
      if (memWriteEnable) mem[memAddr[R-1:0]] <= memWriteData;
    end
  end
  assign memReadData = mem[memAddr[R-1:0]];

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record plus its accept cycle; expected
  // outputs follow from how many cycles have passed since acceptance.
  initial begin : model
    int c, tc, ph;
    bit have, tp, tw, last, idle, inr, resp;
    logic [N-1:0] ta, td, la, ld, rd;
    logic [N-1:0] sh [WORDS];
    bit e_r0, e_r1, e_we, e_v0, e_v1;
    for (int i = 0; i < WORDS; i++) sh[i] = 32'h1000_0000 | i;
    c = 0; tc = 0; have = 0; tp = 0; tw = 0; last = 1;
    ta = '0; td = '0; la = '0; ld = '0;
    forever begin
      @(negedge clk);
      c++;
      if (reset) begin have = 0; last = 1; la = '0; ld = '0; end
      ph = have ? c - tc : 0;
      if (have && ph >= 3) have = 0;
      idle = !have && !reset;
      e_r0 = 0; e_r1 = 0;
      if (idle) begin
        if (reqValid0 && reqValid1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          e_r0 = 1;
`else
          if (last) e_r0 = 1; else e_r1 = 1;
`endif
        end else begin
          e_r0 = reqValid0; e_r1 = reqValid1;
        end
      end
      inr  = (ta >> R) == 0;
      e_we = have && ph == 1 && tw && inr;
      resp = have && ph == 2;
      e_v0 = resp && !tp;
      e_v1 = resp && tp;
      rd   = (inr && !tw) ? sh[ta[R-1:0]] : '0;
      chk("reqReady0", reqReady0, e_r0);
      chk("reqReady1", reqReady1, e_r1);
      chk("memWriteEnable", memWriteEnable, e_we);
      chk("memAddr", memAddr, la);
      chk("memWriteData", memWriteData, ld);
      chk("respValid0", respValid0, e_v0);
      chk("respValid1", respValid1, e_v1);
      chk("respReadData0", respReadData0, e_v0 ? rd : '0);
      chk("respReadData1", respReadData1, e_v1 ? rd : '0);
      chk("respError0", respError0, e_v0 && !inr);
      chk("respError1", respError1, e_v1 && !inr);
      if (e_we) sh[ta[R-1:0]] = td;
      if (e_r0 || e_r1) begin
        have = 1; tc = c; tp = e_r1;
        tw = e_r1 ? reqWrite1 : reqWrite0;
        ta = e_r1 ? reqAddr1 : reqAddr0;
        td = e_r1 ? reqWriteData1 : reqWriteData0;
        last = tp; la = ta; ld = td;
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  // One complete transaction on one port; returns what the bench saw.
  task automatic xact(input bit port, input bit wr, input logic [N-1:0] addr,
                      input logic [N-1:0] data, output bit we, output bit rv,
                      output logic [N-1:0] rdata, output bit err);
    bit got;
    got = 0; we = 0; rv = 0; rdata = '0; err = 0;
    if (port) begin reqValid1 = 1; reqWrite1 = wr; reqAddr1 = addr; reqWriteData1 = data; end
    else      begin reqValid0 = 1; reqWrite0 = wr; reqAddr0 = addr; reqWriteData0 = data; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (port ? reqReady1 : reqReady0) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    reqValid0 = 0; reqValid1 = 0;
    @(negedge clk); we = memWriteEnable;
    @(negedge clk);
    rv    = port ? respValid1 : respValid0;
    rdata = port ? respReadData1 : respReadData0;
    err   = port ? respError1 : respError0;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    bit we, rv, err, prev_rv, consec, got;
    logic [N-1:0] rdata;
    int grants[4];
    int acc[4];
    int ng, c;
    reset = 1;
    reqValid0 = 0; reqValid1 = 0; reqWrite0 = 0; reqWrite1 = 0;
    reqAddr0 = '0; reqAddr1 = '0; reqWriteData0 = '0; reqWriteData1 = '0;

    @(negedge clk);
    chk("rst_memWriteEnable", memWriteEnable, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_respValid0", respValid0, 0);
    @(posedge clk); #1 reset = 0;

    // store then load back
    xact(0, 1, 32'h15, 32'hDEADBEEF, we, rv, rdata, err);
    chk("store15_we", we, 1);
    chk("store15_rv", rv, 1);
    xact(0, 0, 32'h15, 32'h0, we, rv, rdata, err);
    chk("load15_we", we, 0);
    chk("load15_rv", rv, 1);
    chk("load15_data", rdata, 32'hDEADBEEF);

    // out-of-range store
    xact(1, 1, 32'h40, 32'hACACACAC, we, rv, rdata, err);
    chk("oor_we", we, 0);
    chk("oor_rv", rv, 1);
    chk("oor_err", err, 1);
    chk("oor_data", rdata, 0);

    // contended loads from reset
    pulse_reset();
    reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 32'h2A;
    reqValid1 = 1; reqWrite1 = 0; reqAddr1 = 32'h3F;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (reqReady0) begin grants[ng] = 0; ng++; end
      else if (reqReady1) begin grants[ng] = 1; ng++; end
    end
    chk("grant_count", ng, 4);
    @(posedge clk); #1 reqValid0 = 0; reqValid1 = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk($sformatf("grant%0d", k), grants[k], 0);
`else
      chk($sformatf("grant%0d", k), grants[k], k % 2);
`endif
    end
    repeat (3) @(posedge clk);
    #1;

    // reset aborts a store in ACCESS
    reqValid0 = 1; reqWrite0 = 1; reqAddr0 = 32'h3F; reqWriteData0 = 32'h55AA55AA;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (reqReady0) begin got = 1; break; end
    end
    chk("abort_accept", got, 1);
    @(posedge clk); #1 reset = 1; reqValid0 = 0;
    @(negedge clk);
    chk("abort_we", memWriteEnable, 0);
    chk("abort_memAddr", memAddr, 0);
    @(posedge clk); #1 reset = 0;
    consec = 0;
    repeat (3) begin @(negedge clk); if (respValid0) consec = 1; end
    chk("abort_no_resp", consec, 0);
    @(posedge clk); #1;
    xact(0, 0, 32'h3F, 32'h0, we, rv, rdata, err);
    chk("abort_load_data", rdata, 32'h1000_003F);

    // back-to-back loads with valid held through RESP
    reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 32'h15;
    ng = 0; c = 0; prev_rv = 0; consec = 0;
    for (int k = 0; k < 30 && ng < 4; k++) begin
      @(negedge clk);
      c++;
      if (prev_rv && respValid0) consec = 1;
      prev_rv = respValid0;
      if (reqReady0) begin acc[ng] = c; ng++; end
    end
    chk("b2b_count", ng, 4);
    for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap%0d", k), acc[k] - acc[k-1], 3);
    repeat (4) begin @(negedge clk); if (prev_rv && respValid0) consec = 1; prev_rv = respValid0; end
    chk("b2b_no_consec", consec, 0);
    @(posedge clk); #1 reqValid0 = 0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
